// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with 4-beat line refill
module icache_dm #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic        wr_req
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL} state_t;

    state_t              state, state_nxt;
    logic [31:2]         req_addr;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [3:0][31:0]    data_mem [LINES];
    logic [LINES-1:0]    line_valid;
    logic [3:0][31:0]    line_buf;
    logic [1:0]          beat_cnt;
    logic                hit;
    logic                commit;
    logic                unused_addr_bits;

    wire [TAG_W-1:0]   req_tag  = req_addr[31:4+INDEX_W];
    wire [INDEX_W-1:0] req_idx  = req_addr[4+INDEX_W-1:4];
    wire [1:0]         word_sel = req_addr[3:2];

    assign unused_addr_bits = ^addr[1:0];
    assign hit     = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_type = 3'b100;
    assign rd_addr = {req_addr[31:4], 4'b0000};
    assign wr_req  = 1'b0;

    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = 32'd0;
        rd_req    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                addr_ok = valid;
                if (valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    // A hit frees the lookup stage, so the next fetch can enter it this cycle
                    data_ok   = 1'b1;
                    rdata     = data_mem[req_idx][word_sel];
                    addr_ok   = valid;
                    state_nxt = valid ? S_LOOKUP : S_IDLE;
                end else begin
                    state_nxt = S_MISS;
                end
            end
            S_MISS: begin
                rd_req = 1'b1;
                if (rd_rdy) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                if (ret_valid && ret_last) begin
                    // Word 3 is still on the return bus, not yet in the line buffer
                    commit    = 1'b1;
                    data_ok   = 1'b1;
                    rdata     = (word_sel == 2'd3) ? ret_data : line_buf[word_sel];
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            line_valid <= '0;
            beat_cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_MISS && rd_rdy) beat_cnt <= 2'd0;
            if (state == S_REFILL && ret_valid) beat_cnt <= beat_cnt + 2'd1;
            if (commit) line_valid[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (addr_ok && valid) req_addr <= addr[31:2];
        if (state == S_REFILL && ret_valid) line_buf[beat_cnt] <= ret_data;
        if (commit) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= {ret_data, line_buf[2], line_buf[1], line_buf[0]};
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [31:0] addr;
    logic        addr_ok, data_ok, rd_req, wr_req;
    logic [31:0] rdata, rd_addr;
    logic [2:0]  rd_type;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;

    int errors = 0;
    int checks = 0;

    icache_dm #(.INDEX_W(6)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .addr(addr),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid = 0; addr = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        cyc(); cyc();
        #1;
        checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got=%0b exp=0", addr_ok); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%0b exp=0", data_ok); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%0b exp=0", rd_req); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got=%0b exp=0", wr_req); end
        cyc(); resetn = 1;
    endtask

    task automatic test_cold_miss();
        cyc(); valid = 1; addr = 32'h1C00_0008; #1;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL cold_addr_ok got=%0b exp=1", addr_ok); end
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL cold_lookup_data_ok got=%0b exp=0", data_ok); end
        cyc(); #1;
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL cold_rd_req got=%0b exp=1", rd_req); end
        checks++; if (rd_addr !== 32'h1C00_0000) begin errors++; $display("FAIL cold_rd_addr got=%h exp=1c000000", rd_addr); end
        checks++; if (rd_type !== 3'b100) begin errors++; $display("FAIL cold_rd_type got=%b exp=100", rd_type); end
        rd_rdy = 1;
        cyc(); rd_rdy = 0; #1;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL cold_rd_req_drop got=%0b exp=0", rd_req); end
        for (int i = 0; i < 4; i++) begin
            cyc(); ret_valid = 1; ret_data = 32'h11 * (i + 1); ret_last = (i == 3); #1;
            if (i < 3) begin
                checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL cold_beat%0d_data_ok got=%0b exp=0", i, data_ok); end
            end else begin
                checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL cold_last_data_ok got=%0b exp=1", data_ok); end
                checks++; if (rdata !== 32'h33) begin errors++; $display("FAIL cold_rdata got=%h exp=33", rdata); end
                checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL cold_last_addr_ok got=%0b exp=0", addr_ok); end
            end
        end
        cyc(); ret_valid = 0; ret_last = 0; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL cold_data_ok_one_cycle got=%0b exp=0", data_ok); end
    endtask

    task automatic test_back_to_back();
        cyc(); valid = 1; addr = 32'h1C00_000C; #1;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok0 got=%0b exp=1", addr_ok); end
        cyc(); addr = 32'h1C00_0000; #1;
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL b2b_data_ok0 got=%0b exp=1", data_ok); end
        checks++; if (rdata !== 32'h44) begin errors++; $display("FAIL b2b_rdata0 got=%h exp=44", rdata); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok1 got=%0b exp=1", addr_ok); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL b2b_rd_req0 got=%0b exp=0", rd_req); end
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL b2b_data_ok1 got=%0b exp=1", data_ok); end
        checks++; if (rdata !== 32'h11) begin errors++; $display("FAIL b2b_rdata1 got=%h exp=11", rdata); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL b2b_rd_req1 got=%0b exp=0", rd_req); end
        cyc(); #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL b2b_idle_data_ok got=%0b exp=0", data_ok); end
    endtask

    task automatic test_conflict_and_hold();
        cyc(); valid = 1; addr = 32'h1C00_0400;
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL conf_lookup_data_ok got=%0b exp=0", data_ok); end
        cyc(); #1;
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL conf_rd_req got=%0b exp=1", rd_req); end
        checks++; if (rd_addr !== 32'h1C00_0400) begin errors++; $display("FAIL conf_rd_addr got=%h exp=1c000400", rd_addr); end
        rd_rdy = 1;
        cyc(); rd_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1; ret_data = 32'hA0 + i; ret_last = (i == 3); #1;
            if (i == 3) begin
                checks++; if (data_ok !== 1'b1 || rdata !== 32'hA0) begin errors++; $display("FAIL conf_refill got=%0b/%h exp=1/a0", data_ok, rdata); end
            end
            cyc();
        end
        ret_valid = 0; ret_last = 0;
        // original line was evicted: 0x1C00_0000 must miss again, with rd_rdy held low
        valid = 1; addr = 32'h1C00_0000;
        cyc(); valid = 1; addr = 32'h1C00_0010; #1;
        checks++; if (data_ok !== 1'b0 || addr_ok !== 1'b0) begin errors++; $display("FAIL conf_remiss got data_ok=%0b addr_ok=%0b exp=0/0", data_ok, addr_ok); end
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL hold%0d_rd_req got=%0b exp=1", i, rd_req); end
            checks++; if (rd_addr !== 32'h1C00_0000) begin errors++; $display("FAIL hold%0d_rd_addr got=%h exp=1c000000", i, rd_addr); end
            checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL hold%0d_addr_ok got=%0b exp=0", i, addr_ok); end
        end
        rd_rdy = 1; valid = 0;
        cyc(); rd_rdy = 0; #1;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL hold_rd_req_drop got=%0b exp=0", rd_req); end
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1; ret_data = 32'h11 * (i + 1); ret_last = (i == 3); #1;
            if (i == 3) begin
                checks++; if (data_ok !== 1'b1 || rdata !== 32'h11) begin errors++; $display("FAIL hold_refill got=%0b/%h exp=1/11", data_ok, rdata); end
            end
            cyc();
        end
        ret_valid = 0; ret_last = 0;
    endtask

    task automatic test_stray_ret();
        ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
        cyc(); valid = 1; addr = 32'h1C00_0004; ret_data = 32'h0BAD_0BAD;
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL stray_data_ok got=%0b exp=1", data_ok); end
        checks++; if (rdata !== 32'h22) begin errors++; $display("FAIL stray_rdata got=%h exp=22", rdata); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL stray_rd_req got=%0b exp=0", rd_req); end
        cyc(); ret_valid = 0; ret_last = 0;
        valid = 1; addr = 32'h1C00_0008;
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b1 || rdata !== 32'h33) begin errors++; $display("FAIL stray_rehit got=%0b/%h exp=1/33", data_ok, rdata); end
        cyc();
    endtask

    task automatic test_reset_mid_refill();
        valid = 1; addr = 32'h1C00_0408;
        cyc(); valid = 0;
        cyc(); rd_rdy = 1; #1;
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL rmr_rd_req got=%0b exp=1", rd_req); end
        cyc(); rd_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1; ret_data = 32'hC0 + i; #1;
            checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL rmr_beat%0d_data_ok got=%0b exp=0", i, data_ok); end
            cyc();
        end
        resetn = 0; ret_data = 32'hC2; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL rmr_reset_data_ok got=%0b exp=0", data_ok); end
        cyc(); resetn = 1; ret_data = 32'hC3; ret_last = 1; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL rmr_late_beat_data_ok got=%0b exp=0", data_ok); end
        cyc(); ret_valid = 0; ret_last = 0;
        valid = 1; addr = 32'h1C00_0008; #1;
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL rmr_addr_ok got=%0b exp=1", addr_ok); end
        cyc(); valid = 0; #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL rmr_rerequest_hit got=%0b exp=0", data_ok); end
        cyc(); #1;
        checks++; if (rd_req !== 1'b1 || rd_addr !== 32'h1C00_0000) begin errors++; $display("FAIL rmr_rerequest_miss got=%0b/%h exp=1/1c000000", rd_req, rd_addr); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict_and_hold();
        test_stray_ret();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
